// File: rtl/ddr3_pkg.sv
// Shared DDR3 command encodings, init-sequencer state type and timing helpers.
package ddr3_pkg;

  typedef enum logic [3:0] {
    CMD_MRS  = 4'b0000,
    CMD_REF  = 4'b0001,
    CMD_ZQCL = 4'b0110,
    CMD_NOP  = 4'b0111
  } ddr_cmd_t;

  typedef enum logic [3:0] {
    S_RST_LOW,
    S_CKE_WAIT,
    S_XPR,
    S_MR2,
    S_MR3,
    S_MR1,
    S_MR0,
    S_TMRD,
    S_TMOD,
    S_ZQCL,
    S_ZQINIT,
    S_DONE
  } init_state_t;

  function automatic int ns2cyc(real ns, real period);
    return int'($ceil(ns / period));
  endfunction

  function automatic int max2(int a, int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ddr3_init_sequencer.sv
// DDR3 power-up sequencer: RESET#/CKE timing, MR2/MR3/MR1/MR0 programming, ZQCL,
// then a sticky init_done. Commands go out on a registered valid/ready port.
module ddr3_init_sequencer
  import ddr3_pkg::*;
#(
  parameter real                DDR_CLK_PERIOD = 3.0,
  parameter int                 T_RESET_NS     = 200000,
  parameter int                 T_CKE_NS       = 500000,
  parameter int                 T_XPR_NS       = 270,
  parameter int                 T_MRD_CK       = 4,
  parameter int                 T_MOD_CK       = 12,
  parameter int                 T_ZQINIT_CK    = 512,
  parameter int                 ADDR_W         = 14,
  parameter logic [ADDR_W-1:0]  MR0_VAL        = '0,
  parameter logic [ADDR_W-1:0]  MR1_VAL        = '0,
  parameter logic [ADDR_W-1:0]  MR2_VAL        = '0,
  parameter logic [ADDR_W-1:0]  MR3_VAL        = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              ddr_reset_n,
  output logic              ddr_cke,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output ddr_cmd_t          cmd,
  output logic [2:0]        cmd_ba,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic              init_done
);

  // Cycles spent in each wait state. Post-command waits exclude the issue
  // cycle, so command-to-command spacing equals the JEDEC clock count.
  localparam int W_RST = max2(ns2cyc(real'(T_RESET_NS), DDR_CLK_PERIOD), 1);
  localparam int W_CKE = max2(ns2cyc(real'(T_CKE_NS), DDR_CLK_PERIOD), 1);
  localparam int W_XPR = max2(ns2cyc(real'(T_XPR_NS), DDR_CLK_PERIOD), 5);
  localparam int W_MRD = max2(T_MRD_CK - 1, 1);
  localparam int W_MOD = max2(max2(T_MOD_CK, ns2cyc(15.0, DDR_CLK_PERIOD)) - 1, 1);
  localparam int W_ZQ  = max2(T_ZQINIT_CK, 1);
  localparam int W_MAX = max2(max2(max2(W_RST, W_CKE), max2(W_XPR, W_MRD)), max2(W_MOD, W_ZQ));
  localparam int TW    = $clog2(W_MAX + 1);

  localparam logic [TW-1:0] L_RST = TW'(W_RST - 1);
  localparam logic [TW-1:0] L_CKE = TW'(W_CKE - 1);
  localparam logic [TW-1:0] L_XPR = TW'(W_XPR - 1);
  localparam logic [TW-1:0] L_MRD = TW'(W_MRD - 1);
  localparam logic [TW-1:0] L_MOD = TW'(W_MOD - 1);
  localparam logic [TW-1:0] L_ZQ  = TW'(W_ZQ - 1);

  init_state_t       state_q, state_d;
  init_state_t       mr_next_q, mr_next_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic              ddr_reset_n_q, ddr_reset_n_d;
  logic              cke_q, cke_d;
  logic              cmd_valid_q, cmd_valid_d;
  ddr_cmd_t          cmd_q, cmd_d;
  logic [2:0]        ba_q, ba_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              init_done_q, init_done_d;
  logic              timer_done;
  logic              accept;

  assign timer_done = (timer_q == '0);
  assign accept     = cmd_valid_q & cmd_ready;

  always_comb begin
    state_d   = state_q;
    mr_next_d = mr_next_q;
    timer_d   = timer_done ? timer_q : timer_q - TW'(1);
    case (state_q)
      S_RST_LOW:  if (timer_done) begin state_d = S_CKE_WAIT; timer_d = L_CKE; end
      S_CKE_WAIT: if (timer_done) begin state_d = S_XPR;      timer_d = L_XPR; end
      S_XPR:      if (timer_done) state_d = S_MR2;
      S_MR2:      if (accept) begin state_d = S_TMRD; timer_d = L_MRD; mr_next_d = S_MR3; end
      S_MR3:      if (accept) begin state_d = S_TMRD; timer_d = L_MRD; mr_next_d = S_MR1; end
      S_MR1:      if (accept) begin state_d = S_TMRD; timer_d = L_MRD; mr_next_d = S_MR0; end
      S_MR0:      if (accept) begin state_d = S_TMOD; timer_d = L_MOD; end
      S_TMRD:     if (timer_done) state_d = mr_next_q;
      S_TMOD:     if (timer_done) state_d = S_ZQCL;
      S_ZQCL:     if (accept) begin state_d = S_ZQINIT; timer_d = L_ZQ; end
      S_ZQINIT:   if (timer_done) state_d = S_DONE;
      S_DONE:     state_d = S_DONE;
      default:    begin state_d = S_RST_LOW; timer_d = L_RST; end
    endcase

    // Outputs are decoded from the next state so they register with it.
    ddr_reset_n_d = (state_d != S_RST_LOW);
    cke_d         = !(state_d inside {S_RST_LOW, S_CKE_WAIT});
    init_done_d   = (state_d == S_DONE);
    cmd_valid_d   = 1'b0;
    cmd_d         = CMD_NOP;
    ba_d          = 3'd0;
    addr_d        = '0;
    case (state_d)
      S_MR2:   begin cmd_valid_d = 1'b1; cmd_d = CMD_MRS; ba_d = 3'd2; addr_d = MR2_VAL; end
      S_MR3:   begin cmd_valid_d = 1'b1; cmd_d = CMD_MRS; ba_d = 3'd3; addr_d = MR3_VAL; end
      S_MR1:   begin cmd_valid_d = 1'b1; cmd_d = CMD_MRS; ba_d = 3'd1; addr_d = MR1_VAL; end
      S_MR0:   begin cmd_valid_d = 1'b1; cmd_d = CMD_MRS; ba_d = 3'd0; addr_d = MR0_VAL; end
      S_ZQCL:  begin cmd_valid_d = 1'b1; cmd_d = CMD_ZQCL; addr_d[10] = 1'b1; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_RST_LOW;
      mr_next_q     <= S_MR3;
      timer_q       <= L_RST;
      ddr_reset_n_q <= 1'b0;
      cke_q         <= 1'b0;
      cmd_valid_q   <= 1'b0;
      cmd_q         <= CMD_NOP;
      ba_q          <= 3'd0;
      addr_q        <= '0;
      init_done_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      mr_next_q     <= mr_next_d;
      timer_q       <= timer_d;
      ddr_reset_n_q <= ddr_reset_n_d;
      cke_q         <= cke_d;
      cmd_valid_q   <= cmd_valid_d;
      cmd_q         <= cmd_d;
      ba_q          <= ba_d;
      addr_q        <= addr_d;
      init_done_q   <= init_done_d;
    end
  end

  assign ddr_reset_n = ddr_reset_n_q;
  assign ddr_cke     = cke_q;
  assign cmd_valid   = cmd_valid_q;
  assign cmd         = cmd_q;
  assign cmd_ba      = ba_q;
  assign cmd_addr    = addr_q;
  assign init_done   = init_done_q;

endmodule
